// File: rtl/antirrebote_n.sv
// antirrebote_n: parametrised multi-channel debouncer for front-panel
// pushbuttons and switches. Each input is synchronised by two flops and
// then filtered by a per-channel stability counter advanced by a shared
// sample-tick prescaler. The block produces the debounced level plus
// one-cycle rise/fall pulses.
//
// Optional feature: define ANTIRREBOTE_REPEAT_EN to build per-channel
// auto-repeat (rpt pulses while a channel is held high). Without it, rpt
// is tied to 0.
module antirrebote_n #(
  parameter int   CHANNELS     = 3,
  parameter int   DEPTH        = 4,
  parameter int   PRESCALE     = 1,
  parameter logic RESET_LEVEL  = 1'b0,
  parameter int   REPEAT_DELAY = 500,
  parameter int   REPEAT_RATE  = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] rpt
);

  localparam int CW = (DEPTH > 1)    ? $clog2(DEPTH)    : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s;
  logic [PW-1:0]       pcnt;
  logic                tick;
  logic [CW-1:0]       cnt [CHANNELS];
  logic [CHANNELS-1:0] accept;

  // Two-flop synchroniser, running regardless of en.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse s1 into s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= {CHANNELS{RESET_LEVEL}};
      s  <= {CHANNELS{RESET_LEVEL}};
    end else begin
      s1 <= din;
      s  <= s1;
    end
  end

  // Shared prescaler: wraps at PRESCALE-1 while enabled, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (en) begin
      if (pcnt == PW'(PRESCALE - 1)) pcnt <= '0;
      else                           pcnt <= pcnt + 1'b1;
    end
  end

  assign tick = en && (pcnt == PW'(PRESCALE - 1));

  // A channel accepts its new level on the tick that completes DEPTH
  // consecutive differing samples.
  // NOTE: the default assignment first keeps this purely combinational;
  // leaving any bit unassigned on some path would infer a latch.
  always_comb begin
    accept = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      accept[i] = tick && (s[i] != dout[i]) && (cnt[i] == CW'(DEPTH - 1));
    end
  end

  // Per-channel stability counters, debounced level and edge pulses.
  // NOTE: the counter array is a bank of flops, not a RAM, so it is reset
  // element by element like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= {CHANNELS{RESET_LEVEL}};
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (tick) begin
          if (s[i] == dout[i]) begin
            cnt[i] <= '0;
          end else if (accept[i]) begin
            dout[i] <= s[i];
            cnt[i]  <= '0;
            rise[i] <= s[i];
            fall[i] <= ~s[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

`ifdef ANTIRREBOTE_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX) + 1;

  logic [RW-1:0] rcnt [CHANNELS];

  // Auto-repeat: count held ticks after rise, pulse at REPEAT_DELAY and
  // every REPEAT_RATE after that by folding the count back to REPEAT_DELAY.
  // A low level or an accepted fall clears the count and silences rpt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt <= '0;
      for (int i = 0; i < CHANNELS; i++) rcnt[i] <= '0;
    end else begin
      rpt <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!dout[i] || accept[i]) begin
          rcnt[i] <= '0;
        end else if (tick) begin
          if (int'(rcnt[i]) + 1 == REPEAT_DELAY) begin
            rpt[i]  <= 1'b1;
            rcnt[i] <= rcnt[i] + 1'b1;
          end else if (int'(rcnt[i]) + 1 == REPEAT_DELAY + REPEAT_RATE) begin
            rpt[i]  <= 1'b1;
            rcnt[i] <= RW'(REPEAT_DELAY);
          end else begin
            rcnt[i] <= rcnt[i] + 1'b1;
          end
        end
      end
    end
  end
`else
  assign rpt = '0;
`endif

endmodule

// File: doc/antirrebote_n.md
Name: antirrebote_n

Overview:
Parametrised multi-channel debouncer for the pushbuttons and switches on the Nexys 3 front panel. It replaces the fixed 3-channel, 4-sample filter. Each input passes through a 2-FF synchronizer, then a per-channel stability counter driven by a shared sample-tick prescaler. The block outputs the debounced level plus one-cycle rise and fall pulses that the control FSMs consume directly.

Parameters:
CHANNELS, 3, number of independent inputs (>=1)
DEPTH, 4, consecutive differing sample ticks required to accept a new level (>=1)
PRESCALE, 1, clk cycles per sample tick (>=1; 1 = tick every cycle)
RESET_LEVEL, 0, level loaded into synchronizers and dout at reset (0 or 1, all channels)
REPEAT_DELAY, 500, ticks from rise to first repeat pulse (used only with the optional feature, >=1)
REPEAT_RATE, 100, ticks between subsequent repeat pulses (used only with the optional feature, >=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  sample enable; low freezes filtering
din  input  CHANNELS  raw asynchronous button/switch inputs
dout  output  CHANNELS  debounced level (registered)
rise  output  CHANNELS  one-cycle pulse when dout goes 0->1
fall  output  CHANNELS  one-cycle pulse when dout goes 1->0
rpt  output  CHANNELS  auto-repeat pulses (optional feature; constant 0 when disabled)

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset state (rst_n low, asserts immediately):
  - Sync stages and dout = {CHANNELS{RESET_LEVEL}}.
  - Stability counters, prescaler, and repeat counters = 0.
  - rise, fall, and rpt = 0.
  - Release causes no edge pulse.
- Synchronizer: s1 <= din; s <= s1 on every clk, independent of en.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1.
  - tick = en && (pcnt == PRESCALE-1).
  - While en=0, pcnt holds and tick=0.
- Per channel i, on tick:
  - If s[i]==dout[i]: cnt <= 0.
  - Else if cnt == DEPTH-1: dout[i] <= s[i], cnt <= 0, and assert rise[i] or fall[i] for exactly the cycle in which dout[i] first shows the new value.
  - Else: cnt <= cnt+1.
- Without a tick: cnt and dout hold.
- Counter width: max(1, clog2(DEPTH)). DEPTH=1 means the new level is accepted on the first differing tick.
- Latency (PRESCALE=1, en=1): if din changes and holds, dout changes on the rising edge DEPTH+2 after the first edge that samples the new din (2 sync + DEPTH ticks).
  - General case: 2 edges + DEPTH ticks.
- Glitch rejection: any tick with s==dout before the count completes clears cnt. A pulse shorter than DEPTH ticks never reaches dout.
- Channel independence: channels are independent. Simultaneous transitions on several channels produce simultaneous pulses.
- Mutual exclusion: rise and fall are never both high on one channel.
- en low mid-count: count is preserved and resumes when en returns.
- Reset mid-count: all progress is discarded and dout returns to RESET_LEVEL.

Optional Feature:
Macro ANTIRREBOTE_REPEAT_EN.
- Defined: per-channel repeat counter (width clog2(max(REPEAT_DELAY,REPEAT_RATE))+1).
  - Cleared on the rise cycle and whenever dout[i]=0.
  - Increments on tick while dout[i]=1.
  - rpt[i] pulses for one cycle on the tick that completes REPEAT_DELAY ticks after rise, then every REPEAT_RATE ticks while held.
  - The rise cycle itself is not an rpt pulse.
  - Fall stops repeats in the same cycle.
- Undefined: no repeat logic is built; rpt is tied to 0.

Test Plan:
1. Reset release with din=0, RESET_LEVEL=0 -> dout=0, rise=fall=rpt=0 for 20 cycles.
2. CHANNELS=3, DEPTH=4, PRESCALE=1; din[0] 0->1 held -> dout[0]=1 on edge 6 after change; rise[0] high exactly 1 cycle; dout[2:1] unchanged.
3. Same config, din[1] high for 3 cycles then low -> dout[1] stays 0, no pulses. Next, bounce 1,0,1 then hold 1 -> dout[1] rises only after 4 consecutive 1 ticks.
4. PRESCALE=10, DEPTH=4; din[2] 1->0 held -> fall[2] after 2 edges + 4 ticks (~40-50 cycles). Drop en for 30 cycles mid-count -> completion delayed by exactly 30 cycles.
5. Assert rst_n=0 asynchronously mid-count and mid-pulse -> outputs clear without a clock edge. After release, no spurious rise/fall.
6. With ANTIRREBOTE_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, PRESCALE=1; hold din[0]=1 -> rpt[0] pulses 5 ticks after rise, then every 2 ticks; releasing din stops rpt once fall asserts. Without the macro, rpt=0 throughout.
